t_switch_defl_reg: RTL and testbench



---
 rtl/t_switch_defl_reg_pkg.sv | 51 +++++
 rtl/t_switch_defl_reg_if.sv | 24 ++
 rtl/t_switch_defl_reg_arb.sv | 103 ++++++++++
 rtl/t_switch_defl_reg.sv | 113 +++++++++++
 tb/tb_t_switch_defl_reg.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/t_switch_defl_reg_pkg.sv
// rtl/t_switch_defl_reg_pkg.sv - port-select encodings and routing helpers for the deflection T-switch
package t_switch_defl_reg_pkg;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2,
    SEL_U0    = 2'd3
  } sel_e;

  localparam int IDX_L = 0;
  localparam int IDX_R = 1;
  localparam int IDX_U = 2;
  localparam int NPORT = 3;

  function automatic sel_e port_sel(input logic [1:0] idx);
    logic [1:0] t;
    t = idx + 2'd1;
    return sel_e'(t);
  endfunction

  function automatic logic [1:0] sel_idx(input sel_e sel);
    logic [1:0] t;
    t = sel;
    return t - 2'd1;
  endfunction

  // Port codes 1..3 sum to 6, so the third port is whatever the other two leave.
  function automatic sel_e other_legal(input sel_e own, input sel_e wanted);
    logic [2:0] t;
    t = 3'd6 - {1'b0, own} - {1'b0, wanted};
    return sel_e'(t[1:0]);
  endfunction

  function automatic sel_e cyc_a(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_RIGHT;
      2'd1:    return SEL_U0;
      default: return SEL_LEFT;
    endcase
  endfunction

  function automatic sel_e cyc_b(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_U0;
      2'd1:    return SEL_LEFT;
      default: return SEL_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/t_switch_defl_reg_if.sv
// rtl/t_switch_defl_reg_if.sv - packet ports of the T-switch (left, right, up0)
interface t_switch_defl_reg_if #(
  parameter int A_W = 4,
  parameter int D_W = 32
);
  localparam int P_W = A_W + D_W;

  logic           l_i_v,    r_i_v,    u0_i_v;
  logic           l_i_defl, r_i_defl, u0_i_defl;
  logic [P_W-1:0] l_i_d,    r_i_d,    u0_i_d;
  logic           l_o_v,    r_o_v,    u0_o_v;
  logic           l_o_defl, r_o_defl, u0_o_defl;
  logic [P_W-1:0] l_o_d,    r_o_d,    u0_o_d;

  modport master (
    output l_i_v, r_i_v, u0_i_v, l_i_defl, r_i_defl, u0_i_defl, l_i_d, r_i_d, u0_i_d,
    input  l_o_v, r_o_v, u0_o_v, l_o_defl, r_o_defl, u0_o_defl, l_o_d, r_o_d, u0_o_d
  );

  modport slave (
    input  l_i_v, r_i_v, u0_i_v, l_i_defl, r_i_defl, u0_i_defl, l_i_d, r_i_d, u0_i_d,
    output l_o_v, r_o_v, u0_o_v, l_o_defl, r_o_defl, u0_o_defl, l_o_d, r_o_d, u0_o_d
  );
endinterface

// File: rtl/t_switch_defl_reg_arb.sv
// rtl/t_switch_defl_reg_arb.sv - combinational deflection arbiter: every valid input gets a legal output
module t_defl_arb
  import t_switch_defl_reg_pkg::*;
#(
  parameter int A_W  = 4,
  parameter int WRAP = 1,
  parameter int posl = 0,
  parameter int posx = 0
) (
  input  logic [NPORT-1:0]          v_i,
  input  logic [NPORT-1:0]          defl_i,
  input  logic [NPORT-1:0][A_W-1:0] addr_i,
  input  logic                      tog_i,
  output sel_e                      sel_o [NPORT],
  output logic [NPORT-1:0]          defl_o,
  output logic [1:0]                cnt_o
);

  sel_e                  want  [NPORT];
  sel_e                  grant [NPORT];
  logic [NPORT-1:0][2:0] key;
  logic [NPORT-1:0]      is_local;
  logic [NPORT-1:0]      is_hi;
  logic [1:0]            win;
  logic [1:0]            nv;
  logic                  found;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      is_local[i] = (addr_i[i] >> (posl + 1)) == A_W'(posx);
      is_hi[i]    = addr_i[i][posl];
    end
  end

  always_comb begin
    want[IDX_L] = SEL_U0;
    if (is_local[IDX_L])
      want[IDX_L] = (is_hi[IDX_L] || WRAP != 0) ? SEL_RIGHT : SEL_U0;
    want[IDX_R] = SEL_U0;
    if (is_local[IDX_R])
      want[IDX_R] = (!is_hi[IDX_R] || WRAP != 0) ? SEL_LEFT : SEL_U0;
    want[IDX_U] = is_hi[IDX_U] ? SEL_RIGHT : SEL_LEFT;
  end

  // Deflected packets outrank everything; up0 beats the sides, toggle orders left/right.
  assign key[IDX_L] = {defl_i[IDX_L], 1'b0, ~tog_i};
  assign key[IDX_R] = {defl_i[IDX_R], 1'b0, tog_i};
  assign key[IDX_U] = {defl_i[IDX_U], 2'b10};

  always_comb begin
    win   = 2'd0;
    nv    = 2'd0;
    found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (v_i[i]) begin
        nv = nv + 2'd1;
        if (!found || key[i] > key[win]) begin
          win   = 2'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORT; i++) grant[i] = SEL_NONE;
    case (nv)
      2'd1: grant[win] = want[win];
      2'd2: begin
        grant[win] = want[win];
        for (int i = 0; i < NPORT; i++) begin
          if (v_i[i] && 2'(i) != win)
            grant[i] = (want[i] != want[win]) ? want[i] : other_legal(port_sel(2'(i)), want[i]);
        end
      end
      2'd3: begin
        // With all three busy the assignment is one of the two rotations; the winner picks it.
        for (int i = 0; i < NPORT; i++)
          grant[i] = (want[win] == cyc_a(win)) ? cyc_a(2'(i)) : cyc_b(2'(i));
      end
      default: ;
    endcase
  end

  always_comb begin
    defl_o = '0;
    cnt_o  = 2'd0;
    for (int i = 0; i < NPORT; i++) begin
      defl_o[i] = v_i[i] && (grant[i] != want[i]);
      cnt_o     = cnt_o + {1'b0, defl_o[i]};
    end
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      sel_o[o] = SEL_NONE;
      for (int i = 0; i < NPORT; i++) begin
        if (grant[i] == port_sel(2'(o))) sel_o[o] = port_sel(2'(i));
      end
    end
  end

endmodule

// File: rtl/t_switch_defl_reg.sv
// rtl/t_switch_defl_reg.sv - bufferless deflection T-switch with registered outputs and deflection counter
module t_switch_defl_reg
  import t_switch_defl_reg_pkg::*;
#(
  parameter int N     = 8,
  parameter int A_W   = $clog2(N) + 1,
  parameter int D_W   = 32,
  parameter int WRAP  = 1,
  parameter int posl  = 0,
  parameter int posx  = 0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              defl_clr,
  output logic [CNT_W-1:0]  defl_cnt,
  t_switch_defl_reg_if.slave sw
);

  localparam int P_W = A_W + D_W;

  logic [NPORT-1:0][P_W-1:0] d_in;
  logic [NPORT-1:0][A_W-1:0] a_in;
  logic [NPORT-1:0]          v_in;
  logic [NPORT-1:0]          dfl_in;

  sel_e                      sel [NPORT];
  logic [NPORT-1:0]          new_defl;
  logic [1:0]                new_cnt;

  logic [NPORT-1:0]          o_v_q,    o_v_d;
  logic [NPORT-1:0]          o_defl_q, o_defl_d;
  logic [NPORT-1:0][P_W-1:0] o_d_q,    o_d_d;
  logic                      tog_q,    tog_d;
  logic [CNT_W-1:0]          cnt_q,    cnt_d;
  logic [CNT_W:0]            cnt_sum;

  assign d_in[IDX_L] = sw.l_i_d;
  assign d_in[IDX_R] = sw.r_i_d;
  assign d_in[IDX_U] = sw.u0_i_d;
  assign v_in        = {sw.u0_i_v, sw.r_i_v, sw.l_i_v};
  assign dfl_in      = {sw.u0_i_defl, sw.r_i_defl, sw.l_i_defl};

  always_comb begin
    for (int i = 0; i < NPORT; i++) a_in[i] = d_in[i][P_W-1 -: A_W];
  end

  t_defl_arb #(
    .A_W  (A_W),
    .WRAP (WRAP),
    .posl (posl),
    .posx (posx)
  ) u_arb (
    .v_i    (v_in),
    .defl_i (dfl_in),
    .addr_i (a_in),
    .tog_i  (tog_q),
    .sel_o  (sel),
    .defl_o (new_defl),
    .cnt_o  (new_cnt)
  );

  // Idle outputs keep their last packet; only valid and deflected flags drop.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      o_v_d[o]    = 1'b0;
      o_defl_d[o] = 1'b0;
      o_d_d[o]    = o_d_q[o];
      if (sel[o] != SEL_NONE) begin
        o_v_d[o]    = 1'b1;
        o_d_d[o]    = d_in[sel_idx(sel[o])];
        o_defl_d[o] = dfl_in[sel_idx(sel[o])] | new_defl[sel_idx(sel[o])];
      end
    end
  end

  assign tog_d   = ~tog_q;
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, new_cnt};

  always_comb begin
    cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    if (defl_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_v_q    <= '0;
      o_defl_q <= '0;
      o_d_q    <= '0;
      tog_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (ce) begin
      o_v_q    <= o_v_d;
      o_defl_q <= o_defl_d;
      o_d_q    <= o_d_d;
      tog_q    <= tog_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw.l_o_v     = o_v_q[IDX_L];
  assign sw.r_o_v     = o_v_q[IDX_R];
  assign sw.u0_o_v    = o_v_q[IDX_U];
  assign sw.l_o_defl  = o_defl_q[IDX_L];
  assign sw.r_o_defl  = o_defl_q[IDX_R];
  assign sw.u0_o_defl = o_defl_q[IDX_U];
  assign sw.l_o_d     = o_d_q[IDX_L];
  assign sw.r_o_d     = o_d_q[IDX_R];
  assign sw.u0_o_d    = o_d_q[IDX_U];
  assign defl_cnt     = cnt_q;

endmodule

// File: tb/tb_t_switch_defl_reg.sv
// tb/tb_t_switch_defl_reg.sv - self-checking bench for the deflection T-switch
module tb_t_switch_defl_reg;

  localparam int A_W   = 4;
  localparam int D_W   = 8;
  localparam int CNT_W = 16;
  localparam int CMAX  = 65535;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic             defl_clr;
  logic [CNT_W-1:0] defl_cnt;

  t_switch_defl_reg_if #(.A_W(A_W), .D_W(D_W)) sw ();

  t_switch_defl_reg #(
    .N(8), .A_W(A_W), .D_W(D_W), .WRAP(1), .posl(0), .posx(0), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .defl_clr (defl_clr),
    .defl_cnt (defl_cnt),
    .sw       (sw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Port index 0=left, 1=right, 2=up0 for inputs and outputs alike.
  logic       in_v   [3];
  logic       in_dfl [3];
  logic [3:0] in_a   [3];
  logic [7:0] in_dat [3];

  logic        o_v [3];
  logic        o_f [3];
  logic [11:0] o_d [3];
  assign o_v[0] = sw.l_o_v;    assign o_v[1] = sw.r_o_v;    assign o_v[2] = sw.u0_o_v;
  assign o_f[0] = sw.l_o_defl; assign o_f[1] = sw.r_o_defl; assign o_f[2] = sw.u0_o_defl;
  assign o_d[0] = sw.l_o_d;    assign o_d[1] = sw.r_o_d;    assign o_d[2] = sw.u0_o_d;

  logic        m_v [3];
  logic        m_f [3];
  logic [11:0] m_d [3];
  bit          m_tog;
  int          m_cnt;

  task automatic apply();
    sw.l_i_v  = in_v[0];   sw.r_i_v  = in_v[1];   sw.u0_i_v  = in_v[2];
    sw.l_i_defl = in_dfl[0]; sw.r_i_defl = in_dfl[1]; sw.u0_i_defl = in_dfl[2];
    sw.l_i_d  = {in_a[0], in_dat[0]};
    sw.r_i_d  = {in_a[1], in_dat[1]};
    sw.u0_i_d = {in_a[2], in_dat[2]};
  endtask

  task automatic set_in(input int i, input logic v, input logic f, input logic [3:0] a, input logic [7:0] d);
    in_v[i] = v; in_dfl[i] = f; in_a[i] = a; in_dat[i] = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Destination port for an input at level 0, position 0, with wrap enabled.
  function automatic int want_of(input int i, input logic [3:0] a);
    bit loc;
    loc = (a >> 1) == 4'd0;
    if (i == 0) return loc ? 1 : 2;
    if (i == 1) return loc ? 0 : 2;
    return a[0] ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < 3; o++) begin m_v[o] = 0; m_f[o] = 0; m_d[o] = 0; end
    m_tog = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int want [3];
    int key  [3];
    int g    [3];
    int d1   [3];
    int d2   [3];
    int w, n, lo, nd;
    if (!ce) return;
    d1 = '{1, 2, 0};
    d2 = '{2, 0, 1};
    n = 0; w = -1; lo = -1; nd = 0;
    for (int i = 0; i < 3; i++) begin
      want[i] = want_of(i, in_a[i]);
      key[i]  = (in_dfl[i] ? 4 : 0) + ((i == 2) ? 2 : (i == 0) ? (m_tog ? 0 : 1) : (m_tog ? 1 : 0));
      g[i]    = -1;
      if (in_v[i]) begin
        n++;
        if (w < 0 || key[i] > key[w]) w = i;
      end
    end
    if (n == 1) g[w] = want[w];
    if (n == 2) begin
      g[w] = want[w];
      for (int i = 0; i < 3; i++) if (in_v[i] && i != w) lo = i;
      g[lo] = (want[lo] != want[w]) ? want[lo] : 3 - lo - want[lo];
    end
    if (n == 3) begin
      for (int i = 0; i < 3; i++) g[i] = (d1[w] == want[w]) ? d1[i] : d2[i];
    end
    for (int o = 0; o < 3; o++) begin
      m_v[o] = 0;
      m_f[o] = 0;
      for (int i = 0; i < 3; i++) begin
        if (in_v[i] && g[i] == o) begin
          m_v[o] = 1;
          m_d[o] = {in_a[i], in_dat[i]};
          m_f[o] = in_dfl[i] || (g[i] != want[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) if (in_v[i] && g[i] != want[i]) nd++;
    m_cnt = defl_clr ? 0 : ((m_cnt + nd > CMAX) ? CMAX : m_cnt + nd);
    m_tog = !m_tog;
  endtask

  task automatic check_model(input string tag);
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("%s_v%0d", tag, o), 32'(o_v[o]), 32'(m_v[o]));
      chk($sformatf("%s_defl%0d", tag, o), 32'(o_f[o]), 32'(m_f[o]));
      chk($sformatf("%s_d%0d", tag, o), 32'(o_d[o]), 32'(m_d[o]));
    end
    chk($sformatf("%s_cnt", tag), 32'(defl_cnt), 32'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    apply();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 3; i++)
      set_in(i, 1'($urandom), 1'($urandom), 4'($urandom_range(7, 0)), 8'($urandom));
  endtask

  typedef struct {
    logic [2:0] v;
    logic [2:0] dfl;
    logic [3:0] a [3];
    logic [2:0] ev;
    logic [2:0] edfl;
    int         src [3];
    int         inc;
  } vec_t;

  vec_t tbl [6];
  logic [7:0] vdat [3];
  int exp_cnt;

  initial begin
    vdat = '{8'hA5, 8'h5A, 8'h3C};
    tbl[0] = '{3'b001, 3'b000, '{4'd1, 4'd0, 4'd0}, 3'b010, 3'b000, '{-1, 0, -1}, 0};
    tbl[1] = '{3'b000, 3'b000, '{4'd0, 4'd0, 4'd0}, 3'b000, 3'b000, '{-1, -1, -1}, 0};
    tbl[2] = '{3'b011, 3'b000, '{4'd5, 4'd6, 4'd0}, 3'b101, 3'b001, '{1, -1, 0}, 1};
    tbl[3] = '{3'b011, 3'b000, '{4'd5, 4'd6, 4'd0}, 3'b110, 3'b010, '{-1, 0, 1}, 1};
    tbl[4] = '{3'b011, 3'b010, '{4'd5, 4'd6, 4'd0}, 3'b110, 3'b110, '{-1, 0, 1}, 1};
    tbl[5] = '{3'b111, 3'b000, '{4'd1, 4'd4, 4'd0}, 3'b111, 3'b000, '{2, 0, 1}, 0};

    rst = 1'b0; ce = 1'b1; defl_clr = 1'b0;
    for (int i = 0; i < 3; i++) set_in(i, 0, 0, 0, 0);
    apply();
    model_reset();
    repeat (2) @(negedge clk);
    for (int o = 0; o < 3; o++) chk($sformatf("reset_v%0d", o), 32'(o_v[o]), 0);
    chk("reset_cnt", 32'(defl_cnt), 0);
    rst = 1'b1;

    // Random traffic, then reset dropped mid-cycle with all inputs valid.
    for (int k = 0; k < 20; k++) begin randomize_inputs(); cycle("pre"); end
    for (int i = 0; i < 3; i++) set_in(i, 1, 1, 4'(i + 3), 8'(i));
    apply();
    @(posedge clk); model_step();
    #3 rst = 1'b0;
    #1;
    model_reset();
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("async_rst_v%0d", o), 32'(o_v[o]), 0);
      chk($sformatf("async_rst_defl%0d", o), 32'(o_f[o]), 0);
    end
    chk("async_rst_cnt", 32'(defl_cnt), 0);
    @(negedge clk); cycle("rst_hold");
    rst = 1'b1;

    exp_cnt = 0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) set_in(i, tbl[r].v[i], tbl[r].dfl[i], tbl[r].a[i], vdat[i]);
      cycle($sformatf("vec%0d", r));
      exp_cnt += tbl[r].inc;
      for (int o = 0; o < 3; o++) begin
        chk($sformatf("tbl%0d_v%0d", r, o), 32'(o_v[o]), 32'(tbl[r].ev[o]));
        chk($sformatf("tbl%0d_defl%0d", r, o), 32'(o_f[o]), 32'(tbl[r].edfl[o]));
        if (tbl[r].src[o] >= 0)
          chk($sformatf("tbl%0d_d%0d", r, o), 32'(o_d[o]),
              32'({tbl[r].a[tbl[r].src[o]], vdat[tbl[r].src[o]]}));
      end
      chk($sformatf("tbl%0d_cnt", r), 32'(defl_cnt), 32'(exp_cnt));
    end

    // Drive the counter to saturation with two deflections per cycle.
    for (int i = 0; i < 3; i++) set_in(i, 0, 0, 0, 0);
    defl_clr = 1'b1;
    cycle("clr0");
    chk("clr0_zero", 32'(defl_cnt), 0);
    defl_clr = 1'b0;
    set_in(0, 1, 1, 4'd5, 8'h11);
    set_in(1, 1, 0, 4'd6, 8'h22);
    set_in(2, 1, 0, 4'd0, 8'h33);
    for (int k = 0; k < 32767; k++) cycle("sat_ramp");
    chk("sat_below", 32'(defl_cnt), 32'(CMAX - 1));
    cycle("sat_hit");
    chk("sat_hit_max", 32'(defl_cnt), 32'(CMAX));
    cycle("sat_stay");
    chk("sat_stay_max", 32'(defl_cnt), 32'(CMAX));

    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      defl_clr = 1'($urandom);
      cycle("ce_hold");
    end
    chk("ce_hold_cnt", 32'(defl_cnt), 32'(CMAX));
    chk("ce_hold_d_u0", 32'(o_d[2]), 32'({4'd5, 8'h11}));

    ce = 1'b1;
    defl_clr = 1'b1;
    set_in(0, 1, 0, 4'd5, 8'h44);
    set_in(1, 1, 0, 4'd6, 8'h55);
    set_in(2, 0, 0, 4'd0, 8'h00);
    cycle("clr_conflict");
    chk("clr_conflict_cnt", 32'(defl_cnt), 0);
    defl_clr = 1'b0;

    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      ce       = ($urandom_range(7, 0) != 0);
      defl_clr = ($urandom_range(15, 0) == 0);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
